bit_serial_addsub: RTL

- Parametrised bit-serial (digit-serial) adder/subtractor with a start/done handshake.
- Loads two WL-bit operands in parallel and processes DW bits per clock, LSB digit first, through a registered carry.
- Streams each result digit out as it is produced and assembles the full parallel result with carry-out and signed overflow.
- Sits in the datapath wherever area-cheap serial arithmetic is wanted and a controller can wait WL/DW cycles for the result.

---
 rtl/bit_serial_addsub.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bit_serial_addsub.sv
// Digit-serial adder/subtractor with start/done handshake.
// Loads two WL-bit operands, processes DW bits per clock LSB-first through a
// registered carry, streams each result digit and assembles the parallel result.
//
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous active-low reset
//   start      request, accepted only in IDLE or DONE
//   sub        0 = a+b, 1 = a-b (sampled with start)
//   a, b       WL-bit operands (sampled with start)
//   busy       high while shifting
//   sout       current result digit (combinational)
//   sout_valid high while sout is meaningful
//   done       one-cycle pulse, result valid
//   sum        parallel result, held until the next result overwrites it
//   cout       final carry-out (subtract: 1 = no borrow)
//   ovf        signed overflow
module bit_serial_addsub #(
    parameter int unsigned WL = 8,
    parameter int unsigned DW = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic          sub,
    input  logic [WL-1:0] a,
    input  logic [WL-1:0] b,
    output logic          busy,
    output logic [DW-1:0] sout,
    output logic          sout_valid,
    output logic          done,
    output logic [WL-1:0] sum,
    output logic          cout,
    output logic          ovf
);

    localparam int unsigned N  = WL / DW;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [WL-1:0] a_q, a_d;
    logic [WL-1:0] b_q, b_d;
    logic          carry_q, carry_d;
    logic [WL-1:0] res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WL-1:0] sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic          sv_q, sv_d;
    logic          done_q, done_d;

    // Sum of the current low digits plus carry; bit DW is the digit carry-out.
    logic [DW:0]   dsum;

    assign dsum = {1'b0, a_q[DW-1:0]} + {1'b0, b_q[DW-1:0]} + (DW+1)'(carry_q);

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction as a + ~b + 1, the +1 entering via the carry.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d     = a_q >> DW;
                b_d     = b_q >> DW;
                carry_d = dsum[DW];
                res_d   = (res_q >> DW) | (WL'(dsum[DW-1:0]) << (WL - DW));
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    sum_d   = res_d;
                    cout_d  = dsum[DW];
                    // Same-sign operands producing a different-sign result;
                    // equivalent to carry-in XOR carry-out of the MSB.
                    ovf_d   = (a_q[DW-1] ~^ b_q[DW-1]) & (dsum[DW-1] ^ a_q[DW-1]);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
        sv_d   = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            sv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            sv_q    <= sv_d;
            done_q  <= done_d;
        end
    end

    assign sout       = dsum[DW-1:0];
    assign busy       = busy_q;
    assign sout_valid = sv_q;
    assign done       = done_q;
    assign sum        = sum_q;
    assign cout       = cout_q;
    assign ovf        = ovf_q;

endmodule
